aes_iter_cipher_ctrl: RTL and testbench

- Iterative AES encryption controller around one shared round-function datapath.
- Accepts one plaintext block and cipher key over a valid/ready handshake.
- Expands the key one 32-bit word per cycle into a round-key register file, then applies Nr+1 rounds at one round per cycle.
- Returns the ciphertext over a valid/ready handshake. This is the sequential, area-reduced alternative to the fully unrolled Cipher.

---
 rtl/aes_pkg.sv | 93 +++++++++
 rtl/aes_iter_cipher_ctrl_if.sv | 25 ++
 rtl/aes_round_fn.sv | 24 ++
 rtl/aes_sbox.sv | 17 +
 rtl/aes_iter_cipher_ctrl.sv | 237 +++++++++++++++++++++++
 tb/tb_aes_iter_cipher_ctrl.sv | 234 +++++++++++++++++++++++
 6 files changed

// File: rtl/aes_pkg.sv
// Shared AES types, constants and GF(2^8) helpers for the iterative cipher.
package aes_pkg;

    localparam int Nb = 4;

    typedef logic [31:0]  word_t;
    typedef logic [127:0] state_t;

    typedef enum logic [2:0] {
        IDLE,
        KEYEXP,
        ADDKEY0,
        ROUND,
        DONE
    } aes_state_e;

    localparam logic [7:0] RCON [10] = '{
        8'h01, 8'h02, 8'h04, 8'h08, 8'h10,
        8'h20, 8'h40, 8'h80, 8'h1b, 8'h36
    };

    // Rcon[i] for i = 1..10; anything else yields zero.
    function automatic logic [7:0] rcon_byte(input logic [3:0] idx);
        if ((idx >= 4'd1) && (idx <= 4'd10)) begin
            return RCON[idx - 4'd1];
        end
        return 8'h00;
    endfunction

    // Cycles from the acceptance edge to out_valid.
    function automatic int aes_latency(input int nk, input int nr, input bit key_cached);
        return key_cached ? (nr + 1) : (Nb * (nr + 1) - nk + 1 + nr);
    endfunction

    function automatic logic [7:0] xtime(input logic [7:0] a);
        return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
    endfunction

    function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p;
        logic [7:0] x;
        p = 8'h00;
        x = a;
        for (int i = 0; i < 8; i++) begin
            if (b[i]) p = p ^ x;
            x = xtime(x);
        end
        return p;
    endfunction

    // Multiplicative inverse as a^254 (a^2 * a^4 * ... * a^128); maps 0 to 0.
    function automatic logic [7:0] gf_inv(input logic [7:0] a);
        logic [7:0] sq;
        logic [7:0] acc;
        sq  = a;
        acc = 8'h01;
        for (int i = 1; i < 8; i++) begin
            sq  = gf_mul(sq, sq);
            acc = gf_mul(acc, sq);
        end
        return acc;
    endfunction

    // Byte i of the state sits at bits [127-8i -: 8]; row r, column c is byte r+4c.
    function automatic state_t shift_rows(input state_t s);
        state_t r;
        r = '0;
        for (int c = 0; c < 4; c++) begin
            for (int rr = 0; rr < 4; rr++) begin
                r[127 - 8 * (rr + 4 * c) -: 8] = s[127 - 8 * (rr + 4 * ((c + rr) % 4)) -: 8];
            end
        end
        return r;
    endfunction

    function automatic state_t mix_columns(input state_t s);
        state_t     r;
        logic [7:0] a0, a1, a2, a3;
        r = '0;
        for (int c = 0; c < 4; c++) begin
            a0 = s[127 - 32 * c -: 8];
            a1 = s[119 - 32 * c -: 8];
            a2 = s[111 - 32 * c -: 8];
            a3 = s[103 - 32 * c -: 8];
            r[127 - 32 * c -: 8] = xtime(a0) ^ xtime(a1) ^ a1 ^ a2 ^ a3;
            r[119 - 32 * c -: 8] = a0 ^ xtime(a1) ^ xtime(a2) ^ a2 ^ a3;
            r[111 - 32 * c -: 8] = a0 ^ a1 ^ xtime(a2) ^ xtime(a3) ^ a3;
            r[103 - 32 * c -: 8] = xtime(a0) ^ a0 ^ a1 ^ a2 ^ xtime(a3);
        end
        return r;
    endfunction

endpackage

// File: rtl/aes_iter_cipher_ctrl_if.sv
// Plaintext/key request and ciphertext response handshakes of the iterative cipher.
interface aes_iter_cipher_ctrl_if
    import aes_pkg::*;
#(
    parameter int Nk = 4
);
    logic              in_valid;
    logic              in_ready;
    state_t            in;
    logic [32*Nk-1:0]  key;
    logic              out_valid;
    logic              out_ready;
    state_t            out;
    logic              busy;

    modport master (
        output in_valid, in, key, out_ready,
        input  in_ready, out_valid, out, busy
    );

    modport slave (
        input  in_valid, in, key, out_ready,
        output in_ready, out_valid, out, busy
    );
endinterface

// File: rtl/aes_round_fn.sv
// One AES round: SubBytes -> ShiftRows -> MixColumns (skipped on the final round) -> AddRoundKey.
module aes_round_fn
    import aes_pkg::*;
(
    input  state_t i_state,
    input  state_t i_rkey,
    input  logic   i_final,
    output state_t o_state
);
    state_t w_sub;
    state_t w_shift;
    state_t w_mix;

    for (genvar gi = 0; gi < 16; gi++) begin : g_sbox
        aes_sbox u_sbox (
            .i_byte (i_state[127 - 8 * gi -: 8]),
            .o_byte (w_sub[127 - 8 * gi -: 8])
        );
    end

    assign w_shift = shift_rows(w_sub);
    assign w_mix   = mix_columns(w_shift);
    assign o_state = (i_final ? w_shift : w_mix) ^ i_rkey;
endmodule

// File: rtl/aes_sbox.sv
// AES S-box: GF(2^8) inverse followed by the affine transform.
module aes_sbox
    import aes_pkg::*;
(
    input  logic [7:0] i_byte,
    output logic [7:0] o_byte
);
    logic [7:0] w_inv;

    assign w_inv  = gf_inv(i_byte);
    assign o_byte = w_inv
                  ^ {w_inv[6:0], w_inv[7]}
                  ^ {w_inv[5:0], w_inv[7:6]}
                  ^ {w_inv[4:0], w_inv[7:5]}
                  ^ {w_inv[3:0], w_inv[7:4]}
                  ^ 8'h63;
endmodule

// File: rtl/aes_iter_cipher_ctrl.sv
// Iterative AES encryption controller: expands the key one word per cycle into a
// round-key file, then runs one round per cycle through a shared round datapath.
// Optional macro AES_KEY_CACHE_EN keeps the last expanded key and skips key
// expansion when the next block arrives with the same cipher key.
module aes_iter_cipher_ctrl
    import aes_pkg::*;
#(
    parameter int Nk = 4,
    parameter int Nr = 10
) (
    input  logic                   clk,
    input  logic                   rst,
    aes_iter_cipher_ctrl_if.slave  bus
);
    localparam int NW  = Nb * (Nr + 1);
    localparam int CW  = $clog2(NW + 1);
    localparam int RW  = $clog2(Nr + 1);
    localparam int KPW = $clog2(Nk);

    localparam logic [CW-1:0]  WCNT_LAST = CW'(NW - 1);
    localparam logic [RW-1:0]  RND_LAST  = RW'(Nr);
    localparam logic [KPW-1:0] KPOS_LAST = KPW'(Nk - 1);
    localparam logic [KPW-1:0] KPOS_HALF = KPW'(Nk / 2);

    if (Nr != Nk + 6) begin : g_cfg_err
        $error("aes_iter_cipher_ctrl: Nr must equal Nk+6");
    end

    aes_state_e     r_state;
    aes_state_e     w_state_nxt;
    state_t         r_st;
    state_t         r_out;
    word_t          r_w [NW];
    logic [CW-1:0]  r_wcnt;
    logic [KPW-1:0] r_kpos;   // r_wcnt mod Nk
    logic [3:0]     r_rci;    // r_wcnt div Nk, the Rcon index
    logic [RW-1:0]  r_rnd;

    logic           w_accept;
    logic           w_hit;
    logic           w_in_ready;
    logic           w_out_valid;
    logic           w_busy;

    logic [CW-1:0]  w_idx_prev;
    logic [CW-1:0]  w_idx_back;
    logic [CW-1:0]  w_idx_rk;
    word_t          w_prev;
    word_t          w_back;
    word_t          w_sub_in;
    word_t          w_subword;
    word_t          w_temp;
    word_t          w_new;
    state_t         w_rk;
    state_t         w_round_out;

    // ---------------------------------------------------------------- key cache
`ifdef AES_KEY_CACHE_EN
    logic [32*Nk-1:0] r_cache_key;
    logic             r_cache_vld;

    assign w_hit = r_cache_vld && (bus.key == r_cache_key);

    // Flag drops when a new key starts expanding and rises once its schedule is complete.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_cache_vld <= 1'b0;
        end else if (w_accept && !w_hit) begin
            r_cache_vld <= 1'b0;
        end else if ((r_state == KEYEXP) && (r_wcnt == WCNT_LAST)) begin
            r_cache_vld <= 1'b1;
        end
    end

    // Remember which cipher key the round-key file is being built from.
    always_ff @(posedge clk) begin
        if (w_accept && !w_hit) begin
            r_cache_key <= bus.key;
        end
    end
`else
    assign w_hit = 1'b0;
`endif

    // ---------------------------------------------------------------- FSM
    // State register.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Next state and handshake outputs.
    always_comb begin
        w_state_nxt = r_state;
        w_accept    = 1'b0;
        w_in_ready  = 1'b0;
        w_out_valid = 1'b0;
        w_busy      = 1'b1;
        case (r_state)
            IDLE: begin
                w_in_ready = 1'b1;
                w_busy     = 1'b0;
                if (bus.in_valid) begin
                    w_accept    = 1'b1;
                    w_state_nxt = w_hit ? ADDKEY0 : KEYEXP;
                end
            end
            KEYEXP: begin
                if (r_wcnt == WCNT_LAST) w_state_nxt = ADDKEY0;
            end
            ADDKEY0: begin
                w_state_nxt = ROUND;
            end
            ROUND: begin
                if (r_rnd == RND_LAST) w_state_nxt = DONE;
            end
            DONE: begin
                w_out_valid = 1'b1;
                if (bus.out_ready) w_state_nxt = IDLE;
            end
            default: begin
                w_state_nxt = IDLE;
            end
        endcase
    end

    assign bus.in_ready  = w_in_ready;
    assign bus.out_valid = w_out_valid;
    assign bus.busy      = w_busy;
    assign bus.out       = r_out;

    // ---------------------------------------------------------------- key schedule
    assign w_idx_prev = r_wcnt - CW'(1);
    assign w_idx_back = r_wcnt - CW'(Nk);
    assign w_prev     = r_w[w_idx_prev];
    assign w_back     = r_w[w_idx_back];
    assign w_sub_in   = (r_kpos == '0) ? {w_prev[23:0], w_prev[31:24]} : w_prev;

    for (genvar gj = 0; gj < 4; gj++) begin : g_subword
        aes_sbox u_sbox (
            .i_byte (w_sub_in[31 - 8 * gj -: 8]),
            .o_byte (w_subword[31 - 8 * gj -: 8])
        );
    end

    // Per-word transform of w[wcnt-1] before it is folded into w[wcnt-Nk].
    always_comb begin
        w_temp = w_prev;
        if (r_kpos == '0) begin
            w_temp = w_subword ^ {rcon_byte(r_rci), 24'h000000};
        end else if ((Nk == 8) && (r_kpos == KPOS_HALF)) begin
            w_temp = w_subword;
        end
    end

    assign w_new = w_back ^ w_temp;

    // ---------------------------------------------------------------- round datapath
    // Round key r is words 4r..4r+3; r_rnd is 0 during ADDKEY0.
    assign w_idx_rk = CW'({r_rnd, 2'b00});
    assign w_rk     = {r_w[w_idx_rk], r_w[w_idx_rk + CW'(1)],
                       r_w[w_idx_rk + CW'(2)], r_w[w_idx_rk + CW'(3)]};

    aes_round_fn u_round (
        .i_state (r_st),
        .i_rkey  (w_rk),
        .i_final (r_rnd == RND_LAST),
        .o_state (w_round_out)
    );

    // Word, position and round counters.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_wcnt <= '0;
            r_kpos <= '0;
            r_rci  <= '0;
            r_rnd  <= '0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (w_accept) begin
                        r_wcnt <= CW'(Nk);
                        r_kpos <= '0;
                        r_rci  <= 4'd1;
                        r_rnd  <= '0;
                    end
                end
                KEYEXP: begin
                    r_wcnt <= r_wcnt + CW'(1);
                    if (r_kpos == KPOS_LAST) begin
                        r_kpos <= '0;
                        r_rci  <= r_rci + 4'd1;
                    end else begin
                        r_kpos <= r_kpos + KPW'(1);
                    end
                end
                ADDKEY0: begin
                    r_rnd <= RW'(1);
                end
                ROUND: begin
                    if (r_rnd != RND_LAST) r_rnd <= r_rnd + RW'(1);
                end
                default: begin
                end
            endcase
        end
    end

    // Capture block and key on accept, grow the schedule, then fold in round keys.
    always_ff @(posedge clk) begin
        if (w_accept) begin
            r_st <= bus.in;
            for (int i = 0; i < Nk; i++) begin
                r_w[i] <= bus.key[32 * (Nk - i) - 1 -: 32];
            end
        end
        case (r_state)
            KEYEXP:  r_w[r_wcnt] <= w_new;
            ADDKEY0: r_st <= r_st ^ w_rk;
            ROUND:   r_st <= w_round_out;
            default: begin
            end
        endcase
    end

    // Ciphertext register, loaded by the final round and held until the next one.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_out <= '0;
        end else if ((r_state == ROUND) && (r_rnd == RND_LAST)) begin
            r_out <= w_round_out;
        end
    end
endmodule

// File: tb/tb_aes_iter_cipher_ctrl.sv
// Self-checking bench for aes_iter_cipher_ctrl: AES-128/192/256 instances, scoreboard
// of expected ciphertext and latency, backpressure and mid-operation reset.
module tb_aes_iter_cipher_ctrl;
`ifdef AES_KEY_CACHE_EN
    localparam bit CACHE_EN = 1'b1;
`else
    localparam bit CACHE_EN = 1'b0;
`endif

    localparam logic [255:0] K_A   = {128'h2b7e151628aed2a6abf7158809cf4f3c, 128'h0};
    localparam logic [255:0] K_B   = {128'h000102030405060708090a0b0c0d0e0f, 128'h0};
    localparam logic [255:0] K_192 = {192'h000102030405060708090a0b0c0d0e0f1011121314151617, 64'h0};
    localparam logic [255:0] K_256 = 256'h000102030405060708090a0b0c0d0e0f101112131415161718191a1b1c1d1e1f;
    localparam logic [127:0] PT_A  = 128'h3243f6a8885a308d313198a2e0370734;
    localparam logic [127:0] PT_B  = 128'h00112233445566778899aabbccddeeff;
    localparam logic [127:0] CT_A  = 128'h3925841d02dc09fbdc118597196a0b32;
    localparam logic [127:0] CT_B  = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
    localparam logic [127:0] CT_192 = 128'hdda97ca4864cdfe06eaf70a0ec0d7191;
    localparam logic [127:0] CT_256 = 128'h8ea2b7ca516745bfeafc49904b496089;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    aes_iter_cipher_ctrl_if #(.Nk(4)) if4 ();
    aes_iter_cipher_ctrl_if #(.Nk(6)) if6 ();
    aes_iter_cipher_ctrl_if #(.Nk(8)) if8 ();

    aes_iter_cipher_ctrl #(.Nk(4), .Nr(10)) u_dut4 (.clk(clk), .rst(rst), .bus(if4));
    aes_iter_cipher_ctrl #(.Nk(6), .Nr(12)) u_dut6 (.clk(clk), .rst(rst), .bus(if6));
    aes_iter_cipher_ctrl #(.Nk(8), .Nr(14)) u_dut8 (.clk(clk), .rst(rst), .bus(if8));

    int           sel;
    logic         tb_in_valid;
    logic         tb_out_ready;
    logic [127:0] tb_pt;
    logic [255:0] tb_key;

    assign if4.in_valid  = tb_in_valid && (sel == 4);
    assign if6.in_valid  = tb_in_valid && (sel == 6);
    assign if8.in_valid  = tb_in_valid && (sel == 8);
    assign if4.in        = tb_pt;
    assign if6.in        = tb_pt;
    assign if8.in        = tb_pt;
    assign if4.key       = tb_key[255:128];
    assign if6.key       = tb_key[255:64];
    assign if8.key       = tb_key;
    assign if4.out_ready = tb_out_ready;
    assign if6.out_ready = tb_out_ready;
    assign if8.out_ready = tb_out_ready;

    logic         obs_in_ready;
    logic         obs_out_valid;
    logic         obs_busy;
    logic [127:0] obs_out;

    always_comb begin
        obs_in_ready  = if4.in_ready;
        obs_out_valid = if4.out_valid;
        obs_busy      = if4.busy;
        obs_out       = if4.out;
        if (sel == 6) begin
            obs_in_ready  = if6.in_ready;
            obs_out_valid = if6.out_valid;
            obs_busy      = if6.busy;
            obs_out       = if6.out;
        end else if (sel == 8) begin
            obs_in_ready  = if8.in_ready;
            obs_out_valid = if8.out_valid;
            obs_busy      = if8.busy;
            obs_out       = if8.out;
        end
    end

    int n_chk = 0;
    int n_err = 0;

    task automatic check_eq(input string tag, input logic [255:0] act, input logic [255:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, act, exp);
        end
    endtask

    typedef struct {
        logic [127:0] ct;
        int           lat;
        int           acc;
    } sb_t;

    sb_t sb_q[$];

    int edge_n = 0;
    always @(posedge clk) edge_n <= edge_n + 1;

    // Reference key-cache state per instance (index (Nk-4)/2).
    bit           c_vld [3];
    logic [255:0] c_key [3];

    // Output monitor: on each rising out_valid pop the oldest expectation.
    logic prev_ov = 1'b0;
    always @(negedge clk) begin
        sb_t e;
        if (obs_out_valid === 1'b1 && prev_ov !== 1'b1) begin
            check_eq("sb_pending", (sb_q.size() != 0), 1);
            if (sb_q.size() != 0) begin
                e = sb_q.pop_front();
                check_eq("ciphertext", obs_out, e.ct);
                check_eq("latency", edge_n - e.acc, e.lat);
            end
        end
        prev_ov <= obs_out_valid;
    end

    task automatic run_block(input int nk, input logic [255:0] k, input logic [127:0] pt,
                             input logic [127:0] ct, input int bp);
        int  ix;
        int  nr;
        int  lat;
        int  waited;
        sb_t e;
        ix  = (nk - 4) / 2;
        nr  = nk + 6;
        lat = (CACHE_EN && c_vld[ix] && (c_key[ix] == k)) ? (nr + 1) : (4 * (nr + 1) - nk + 1 + nr);
        sel = nk;
        tb_key = k;
        tb_pt  = pt;
        tb_out_ready = (bp == 0);
        @(negedge clk);
        check_eq("in_ready_idle", obs_in_ready, 1);
        tb_in_valid = 1'b1;
        @(posedge clk);
        #1;
        e.ct  = ct;
        e.lat = lat;
        e.acc = edge_n;
        sb_q.push_back(e);
        // Inputs must be ignored after the acceptance edge, and in_valid while busy.
        tb_pt  = ~pt;
        tb_key = ~k;
        @(negedge clk);
        check_eq("busy_after_accept", obs_busy, 1);
        check_eq("in_ready_busy", obs_in_ready, 0);
        waited = 0;
        while (obs_out_valid !== 1'b1 && waited < 200) begin
            @(negedge clk);
            waited++;
        end
        tb_in_valid = 1'b0;
        check_eq("out_valid_seen", obs_out_valid, 1);
        for (int i = 0; i < bp; i++) begin
            @(negedge clk);
            check_eq("bp_valid", obs_out_valid, 1);
            check_eq("bp_out", obs_out, ct);
            check_eq("bp_in_ready", obs_in_ready, 0);
        end
        tb_out_ready = 1'b1;
        @(negedge clk);
        check_eq("idle_out_valid", obs_out_valid, 0);
        check_eq("idle_in_ready", obs_in_ready, 1);
        check_eq("idle_busy", obs_busy, 0);
        check_eq("out_held", obs_out, ct);
        c_vld[ix] = 1'b1;
        c_key[ix] = k;
    endtask

    task automatic reset_mid_keyexp();
        sel = 4;
        tb_key = K_A;
        tb_pt  = PT_A;
        tb_out_ready = 1'b1;
        @(negedge clk);
        tb_in_valid = 1'b1;
        @(posedge clk);
        #1;
        repeat (20) @(negedge clk);
        check_eq("rst_pre_busy", obs_busy, 1);
        check_eq("rst_pre_in_ready", obs_in_ready, 0);
        rst = 1'b1;
        @(negedge clk);
        check_eq("rst_mid_busy", obs_busy, 0);
        check_eq("rst_mid_out_valid", obs_out_valid, 0);
        check_eq("rst_mid_in_ready", obs_in_ready, 1);
        check_eq("rst_mid_out", obs_out, 0);
        rst = 1'b0;
        tb_in_valid = 1'b0;
        for (int i = 0; i < 3; i++) c_vld[i] = 1'b0;
        repeat (3) @(negedge clk);
        check_eq("rst_post_out_valid", obs_out_valid, 0);
    endtask

    initial begin
        rst = 1'b1;
        sel = 4;
        tb_in_valid  = 1'b0;
        tb_out_ready = 1'b1;
        tb_pt  = '0;
        tb_key = '0;
        for (int i = 0; i < 3; i++) begin
            c_vld[i] = 1'b0;
            c_key[i] = '0;
        end
        repeat (3) @(posedge clk);
        @(negedge clk);
        for (int n = 4; n <= 8; n += 2) begin
            sel = n;
            #1;
            check_eq("reset_in_ready", obs_in_ready, 1);
            check_eq("reset_out_valid", obs_out_valid, 0);
            check_eq("reset_busy", obs_busy, 0);
            check_eq("reset_out", obs_out, 0);
        end
        @(negedge clk);
        rst = 1'b0;

        run_block(4, K_A,   PT_A, CT_A,   0);
        run_block(4, K_A,   PT_A, CT_A,   5);
        run_block(4, K_B,   PT_B, CT_B,   0);
        run_block(6, K_192, PT_B, CT_192, 0);
        run_block(6, K_192, PT_B, CT_192, 0);
        run_block(8, K_256, PT_B, CT_256, 0);
        run_block(8, K_256, PT_B, CT_256, 2);
        reset_mid_keyexp();
        run_block(4, K_A,   PT_A, CT_A,   0);
        run_block(4, K_A,   PT_A, CT_A,   0);
        run_block(4, K_B,   PT_B, CT_B,   0);

        repeat (4) @(negedge clk);
        check_eq("sb_drained", sb_q.size(), 0);
        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end
endmodule
